// File: rtl/main_fsm_if.sv
// main_fsm_if: control/status bundle between the main FSM and the multicycle datapath
// Ports (master = FSM side):
//   in  op[6:0], zero, mem_ready              - opcode, ALU zero flag, memory completion
//   out PCWrite, AdrSrc, MemWrite, IRWrite    - PC/IR enables, address select, memory write
//   out ResultSrc, ALUSrcA, ALUSrcB, ALUOp    - datapath selects and ALU controller code
//   out RegWrite, instr_done, illegal_op      - register write, end-of-instruction and bad-opcode pulses
//   out state[3:0]                            - current FSM state for debug
interface main_fsm_if;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [1:0] ALUOp;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;
    modport master (
        input  op, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ALUOp, instr_done, illegal_op, state
    );
    modport slave (
        output op, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ALUOp, instr_done, illegal_op, state
    );
endinterface

// File: rtl/main_fsm.sv
// main_fsm: multicycle RV32I control FSM (fetch/decode/execute/memory/writeback)
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset, forces FETCH and masks all write enables
//   b     - main_fsm_if.master: opcode/zero/mem_ready in, datapath controls out
module main_fsm (
    input logic        clk,
    input logic        rst_n,
    main_fsm_if.master b
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
    } state_t;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    state_t cur, nxt;
    logic   pc_update, branch, legal;
    always_ff @(posedge clk)
        cur <= !rst_n ? FETCH : nxt;
    always_comb begin
        case (cur)
            FETCH:    nxt = b.mem_ready ? DECODE : FETCH;
            DECODE:   nxt = (b.op == OP_LW || b.op == OP_SW) ? MEMADR :
                            b.op == OP_R   ? EXECR :
                            b.op == OP_I   ? EXECI :
                            b.op == OP_BEQ ? BEQ :
                            b.op == OP_JAL ? JAL : FETCH;
            MEMADR:   nxt = b.op == OP_LW ? MEMREAD : MEMWRITE;
            MEMREAD:  nxt = b.mem_ready ? MEMWB : MEMREAD;
            MEMWRITE: nxt = b.mem_ready ? FETCH : MEMWRITE;
            EXECR:    nxt = ALUWB;
            EXECI:    nxt = ALUWB;
            JAL:      nxt = ALUWB;
            default:  nxt = FETCH;
        endcase
    end
    // Write enables are masked by rst_n so a reset mid-instruction never commits state.
    always_comb begin
        legal        = b.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};
        pc_update    = (cur == FETCH && b.mem_ready) || cur == JAL;
        branch       = cur == BEQ;
        b.PCWrite    = rst_n && (pc_update || (branch && b.zero));
        b.IRWrite    = rst_n && cur == FETCH && b.mem_ready;
        b.MemWrite   = rst_n && cur == MEMWRITE;
        b.RegWrite   = rst_n && (cur == MEMWB || cur == ALUWB);
        b.AdrSrc     = cur inside {MEMREAD, MEMWRITE};
        b.ResultSrc  = cur == FETCH ? 2'b10 : cur == MEMWB ? 2'b01 : 2'b00;
        b.ALUSrcA    = cur inside {MEMADR, EXECR, EXECI, BEQ} ? 2'b10 :
                       cur inside {DECODE, JAL} ? 2'b01 : 2'b00;
        b.ALUSrcB    = cur inside {FETCH, JAL} ? 2'b10 :
                       cur inside {DECODE, MEMADR, EXECI} ? 2'b01 : 2'b00;
        b.ALUOp      = cur inside {EXECR, EXECI} ? 2'b10 : cur == BEQ ? 2'b01 : 2'b00;
        b.illegal_op = cur == DECODE && !legal;
        b.instr_done = cur inside {MEMWB, ALUWB, BEQ} || (cur == MEMWRITE && b.mem_ready) ||
                       (cur == DECODE && !legal);
        b.state      = cur;
    end
endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed self-checking bench for main_fsm with a per-cycle schedule model
module tb_main_fsm;
    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1110011;

    typedef struct {
        int         st;
        bit         chk;
        logic       r, mr, z;
        logic [6:0] op;
    } ent_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, ad, mw, ir;
        logic [1:0] rs, sa, sb;
        logic       rw;
        logic [1:0] aop;
        logic       done, ill;
    } obs_t;

    logic clk = 0;
    logic rst_n = 0;
    int vectors = 0;
    int miscompares = 0;
    ent_t q[$];
    obs_t hist[$];

    main_fsm_if bus();
    main_fsm dut (.clk(clk), .rst_n(rst_n), .b(bus.master));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic obs_t sample();
        obs_t o;
        o = {bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
             bus.ALUSrcA, bus.ALUSrcB, bus.RegWrite, bus.ALUOp, bus.instr_done, bus.illegal_op};
        return o;
    endfunction

    // Expected controls for one cycle, straight from the per-state table of the control spec.
    function automatic obs_t model(ent_t e);
        obs_t x;
        logic pcu, br, ok;
        x = '0;
        pcu = 0;
        br = 0;
        ok = e.op == LW || e.op == SW || e.op == RT || e.op == IT || e.op == BQ || e.op == JL;
        x.st = e.st[3:0];
        case (e.st)
            0:  begin x.sb = 2; x.rs = 2; x.ir = e.mr; pcu = e.mr; end
            1:  begin x.sa = 1; x.sb = 1; x.ill = !ok; x.done = !ok; end
            2:  begin x.sa = 2; x.sb = 1; end
            3:  x.ad = 1;
            4:  begin x.rs = 1; x.rw = 1; x.done = 1; end
            5:  begin x.ad = 1; x.mw = 1; x.done = e.mr; end
            6:  begin x.sa = 2; x.aop = 2; end
            7:  begin x.sa = 2; x.sb = 1; x.aop = 2; end
            8:  begin x.rw = 1; x.done = 1; end
            9:  begin x.sa = 2; x.aop = 1; br = 1; x.done = 1; end
            10: begin x.sa = 1; x.sb = 2; pcu = 1; end
            default: ;
        endcase
        x.pcw = pcu | (br & e.z);
        if (!e.r) begin
            x.pcw = 0;
            x.ir = 0;
            x.mw = 0;
            x.rw = 0;
        end
        return x;
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            ent_t e;
            obs_t g, x;
            e = q.pop_front();
            g = sample();
            x = model(e);
            if (!e.chk) x.st = g.st;
            vectors++;
            if (g !== x) begin
                miscompares++;
                $display("FAIL cycle_outputs @%0t: got %h, expected %h (model state %0d)", $time, g, x, e.st);
            end
        end
    end

    task automatic lit(string nm, int got, int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    task automatic step(logic r, logic mr, logic z, logic [6:0] o, int st);
        ent_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        bus.mem_ready = mr;
        bus.zero = z;
        bus.op = o;
        e.st = st;
        e.chk = 1;
        e.r = r;
        e.mr = mr;
        e.z = z;
        e.op = o;
        q.push_back(e);
        @(negedge clk);
        #1;
        hist.push_back(sample());
    endtask

    // Builds the state visit schedule of one instruction from its class, then plays it.
    task automatic instr(string nm, logic [6:0] o, int fs, int ms, logic z, logic im, int exp_n);
        int sts[$];
        logic mrs[$];
        int k;
        hist.delete();
        repeat (fs) begin sts.push_back(0); mrs.push_back(0); end
        sts.push_back(0); mrs.push_back(1);
        sts.push_back(1); mrs.push_back(im);
        case (o)
            LW: begin
                sts.push_back(2); mrs.push_back(im);
                repeat (ms) begin sts.push_back(3); mrs.push_back(0); end
                sts.push_back(3); mrs.push_back(1);
                sts.push_back(4); mrs.push_back(im);
            end
            SW: begin
                sts.push_back(2); mrs.push_back(im);
                repeat (ms) begin sts.push_back(5); mrs.push_back(0); end
                sts.push_back(5); mrs.push_back(1);
            end
            RT: begin sts.push_back(6); mrs.push_back(im); sts.push_back(8); mrs.push_back(im); end
            IT: begin sts.push_back(7); mrs.push_back(im); sts.push_back(8); mrs.push_back(im); end
            BQ: begin sts.push_back(9); mrs.push_back(im); end
            JL: begin sts.push_back(10); mrs.push_back(im); sts.push_back(8); mrs.push_back(im); end
            default: ;
        endcase
        foreach (sts[i]) step(1, mrs[i], z, o, sts[i]);
        k = 0;
        foreach (hist[i]) if (k == 0 && hist[i].done) k = i + 1;
        lit({nm, "_cycles"}, k, exp_n);
    endtask

    initial begin
        bus.op = 0;
        bus.zero = 0;
        bus.mem_ready = 0;
        hist.delete();
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        lit("reset_state", hist[1].st, 0);
        lit("reset_irwrite_masked", hist[0].ir, 0);
        step(1, 0, 0, 0, 0);

        instr("rtype", RT, 0, 0, 0, 1, 4);
        lit("rtype_aluop", hist[2].aop, 2);
        lit("rtype_regwrite_exec", hist[2].rw, 0);
        lit("rtype_regwrite_wb", hist[3].rw, 1);

        instr("lw", LW, 0, 2, 0, 1, 7);
        lit("lw_adrsrc", hist[3].ad, 1);
        lit("lw_resultsrc", hist[6].rs, 1);
        lit("lw_regwrite", hist[6].rw, 1);

        instr("beq_taken", BQ, 0, 0, 1, 1, 3);
        lit("beq_taken_pcwrite", hist[2].pcw, 1);
        lit("beq_taken_aluop", hist[2].aop, 1);
        instr("beq_not_taken", BQ, 0, 0, 0, 1, 3);
        lit("beq_not_taken_pcwrite", hist[2].pcw, 0);
        lit("beq_not_taken_aluop", hist[2].aop, 1);

        instr("sw_stall", SW, 3, 0, 0, 1, 7);
        lit("sw_ir_stall0", hist[0].ir, 0);
        lit("sw_ir_stall2", hist[2].ir, 0);
        lit("sw_ir_go", hist[3].ir, 1);
        lit("sw_memwrite", hist[6].mw, 1);
        lit("sw_memwrite_memadr", hist[5].mw, 0);

        instr("illegal", BAD, 0, 0, 0, 1, 2);
        lit("illegal_pulse", hist[1].ill, 1);
        lit("illegal_done", hist[1].done, 1);

        instr("itype_mr_ignored", IT, 0, 0, 0, 0, 4);
        instr("jal", JL, 0, 0, 0, 1, 4);
        lit("jal_pcwrite", hist[2].pcw, 1);
        instr("sw_mem_wait", SW, 0, 2, 0, 1, 6);

        hist.delete();
        step(1, 1, 0, LW, 0);
        step(1, 0, 0, LW, 1);
        step(1, 0, 0, LW, 2);
        step(1, 0, 0, LW, 3);
        step(0, 0, 0, LW, 3);
        step(0, 0, 0, LW, 0);
        step(1, 0, 0, LW, 0);
        lit("rst_memread_mw", hist[4].mw, 0);
        lit("rst_memread_rw", hist[4].rw, 0);
        lit("rst_second_rw", hist[5].rw, 0);
        lit("rst_after_state", hist[6].st, 0);

        hist.delete();
        step(1, 1, 0, SW, 0);
        step(1, 0, 0, SW, 1);
        step(1, 0, 0, SW, 2);
        step(1, 0, 0, SW, 5);
        step(0, 0, 0, SW, 5);
        step(1, 0, 0, SW, 0);
        lit("sw_wait_memwrite", hist[3].mw, 1);
        lit("rst_memwrite_masked", hist[4].mw, 0);
        lit("rst_from_memwrite_state", hist[5].st, 0);

        instr("lw_after_reset", LW, 1, 0, 0, 1, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
